psum_fifo: RTL and testbench
============================

# psum_fifo

Inter-PE partial-sum FIFO, the far end of the PE psum handshake. The upstream PE pushes opsum pixels with push/full. The downstream PE consumes them with pop/empty, reading the head word in the same cycle it pops. Instances sit between vertically adjacent PEs in the PE array, and between the last PE row and the psum return path.

## Interface
- DATA_WIDTH, 16, psum pixel width
- DEPTH, 4, number of entries; any value ≥ 2, not necessarily a power of two
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL

- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- clear  input  1  synchronous flush; highest priority
- push  input  1  write request from upstream PE (push_opsum)
- din  input  DATA_WIDTH  pixel written on accepted push
- full  output  1  count == DEPTH; drives upstream opsum_fifo_full
- pop  input  1  read request from downstream PE (pop_ipsum)
- dout  output  DATA_WIDTH  head entry, valid whenever empty==0 (first-word-fall-through); 0 when empty
- empty  output  1  count == 0; drives downstream ipsum_fifo_empty
- count  output  $clog2(DEPTH+1)  current occupancy
- almost_full  output  1  count ≥ AF_LEVEL
- overflow  output  1  sticky: a push was attempted while full
- underflow  output  1  sticky: a pop was attempted while empty

## Operation
- Storage: DEPTH-entry register array, write pointer wr_ptr, read pointer rd_ptr, occupancy counter count.
- Pointers wrap from DEPTH-1 to 0 by explicit compare, not by bit truncation.
- full, empty and almost_full are decoded from the registered count; they carry no combinational path from push or pop.
- Accepted push = push & ~full: mem[wr_ptr] ← din; wr_ptr advances.
- Accepted pop = pop & ~empty: rd_ptr advances.
- Acceptance of push depends only on full. A push while full is refused even if a pop happens in the same cycle. This rule is fixed.
- Acceptance of pop depends only on empty. There is no bypass: a push into an empty FIFO is never poppable in the same cycle.
- Count update: +1 on push only, −1 on pop only, unchanged when both or neither are accepted.
- Refused push sets overflow; memory and pointers are unchanged. Refused pop sets underflow; pointers are unchanged.
- Sticky flags clear only on reset or clear.
- dout = empty ? 0 : mem[rd_ptr]. Combinational from registers only, never from din.
- clear: pointers, count, overflow and underflow go to 0. Any push or pop in the same cycle is ignored. Memory contents are not cleared.

## Timing
- Reset values: full=0, empty=1, count=0, almost_full=0 (for AF_LEVEL ≥ 1), overflow=0, underflow=0, dout=0. Pointers=0.
- Reset assertion takes effect immediately and asynchronously. Deassertion is sampled synchronously, and the first push may follow on the next edge.
- Reset mid-operation discards all contents. empty=1 from the reset assertion onward.
- Push-to-visible latency is 1 cycle: a push at edge t gives empty=0 and dout=din after edge t.
- Pop consumes the word presented on dout before the edge. The next word, or 0 if the FIFO becomes empty, appears after the edge.
- Throughput is one push and one pop per cycle sustained when 0 < count < DEPTH.
- full deasserts in the cycle after the first accepted pop from the full state. empty deasserts in the cycle after the first accepted push into the empty state.
- Simultaneous clear with push/pop: clear wins and the FIFO is empty next cycle.

## Test plan
- Reset then idle, with DEPTH=4: after reset deasserts, empty=1, full=0, count=0, dout=0, flags=0 for 5 cycles.
- Fill and drain, with DEPTH=4: push 0x0011, 0x0022, 0x0033, 0x0044 on consecutive cycles.
  - count steps 1..4; almost_full=1 at count 3; full=1 after the 4th push.
  - Then pop 4 cycles: dout shows 0x0011..0x0044 in order, and empty=1 with dout=0 afterward.
- Streaming: hold count at 2 while pushing and popping every cycle for 20 cycles with an incrementing pattern.
  - Output sequence equals the input sequence.
  - count stays at 2.
  - Both pointers wrap at least 4 times.
- Full-with-pop, with count=4: assert push with din=0x0BAD and pop together.
  - Pop is accepted, push is refused, overflow=1, count=3.
  - 0x0BAD never appears on dout.
- Empty boundary, with count=0: assert pop and push (din=0x00AA) together.
  - underflow=1 and dout=0 in that cycle.
  - Next cycle: empty=0, dout=0x00AA, count=1.
- Clear and async reset:
  - With count=3 and overflow=1, assert clear together with push: next cycle count=0, empty=1, flags=0.
  - Refill to 2 entries, then pulse reset low mid-cycle: outputs return to their reset values before the next edge.

Source files
------------

// File: rtl/psum_fifo_if.sv
// Partial-sum FIFO handshake bundle: upstream push/full side and downstream pop/empty side.
// master drives requests and write data, slave is the FIFO itself.
interface psum_fifo_if #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned Depth     = 4
);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic                 push;
  logic [DataWidth-1:0] din;
  logic                 full;
  logic                 pop;
  logic [DataWidth-1:0] dout;
  logic                 empty;
  logic [CntW-1:0]      count;
  logic                 almost_full;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output push, din, pop,
    input  full, dout, empty, count, almost_full, overflow, underflow
  );

  modport slave (
    input  push, din, pop,
    output full, dout, empty, count, almost_full, overflow, underflow
  );
endinterface

// File: rtl/psum_fifo.sv
// Inter-PE partial-sum FIFO with first-word-fall-through output and sticky error flags.
// Status outputs decode only the registered count, so push/pop never reach them combinationally.
module psum_fifo #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned Depth     = 4,
  parameter int unsigned AfLevel   = Depth - 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  psum_fifo_if.slave  bus
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);
  localparam logic [CntW-1:0] AfCnt   = CntW'(AfLevel);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 full, empty, push_ok, pop_ok;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign push_ok = bus.push & ~full & ~clear_i;
  assign pop_ok  = bus.pop & ~empty & ~clear_i;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (bus.push && full) overflow_d = 1'b1;
      if (bus.pop && empty) underflow_d = 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; empty masks stale words on dout.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.din;
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.count       = count_q;
  assign bus.almost_full = (count_q >= AfCnt);
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.dout        = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: tb/tb_psum_fifo.sv
// Directed bench for psum_fifo (DEPTH=4): vector table plus streaming and async-reset sequences.
module tb_psum_fifo;
  logic clk;
  logic rst_n;
  logic clear;
  int   total;
  int   bad;

  psum_fifo_if #(.DataWidth(16), .Depth(4)) bus ();

  psum_fifo #(.DataWidth(16), .Depth(4), .AfLevel(3)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        push;
    logic        pop;
    logic [15:0] din;
    logic [15:0] pre_dout;
    logic [2:0]  cnt;
    logic        empty;
    logic        full;
    logic        af;
    logic        ov;
    logic        un;
    logic [15:0] dout;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] cnt, input logic e,
                           input logic f, input logic af, input logic ov, input logic un,
                           input logic [15:0] dout);
    chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
    chk({tag, ".flags"}, {27'd0, bus.empty, bus.full, bus.almost_full, bus.overflow,
        bus.underflow}, {27'd0, e, f, af, ov, un});
    chk({tag, ".dout"}, 32'(bus.dout), 32'(dout));
  endtask

  task automatic drive(input logic c, input logic p, input logic o, input logic [15:0] d);
    clear    = c;
    bus.push = p;
    bus.pop  = o;
    bus.din  = d;
  endtask

  initial begin
    logic [15:0] model_q [$];
    logic [15:0] exp_w;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0);

    //          clr   push  pop   din       pre_dout  cnt   empty full  af    ov    un    dout
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0011};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0022, 16'h0011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0011};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0033, 16'h0011, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0011};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0044, 16'h0011, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0011};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0011, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0022};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0022, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0033};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0033, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0044};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0044, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h00AA, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00AA};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0055, 16'h00AA, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00AA};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0066, 16'h00AA, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00AA};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0077, 16'h00AA, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00AA};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 16'h0BAD, 16'h00AA, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0055};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 16'h0099, 16'h0055, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk_state($sformatf("idle%0d", i), 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    end

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].clr, vecs[i].push, vecs[i].pop, vecs[i].din);
      #1 chk($sformatf("vec%0d.pre_dout", i), 32'(bus.dout), 32'(vecs[i].pre_dout));
      @(posedge clk);
      #1 chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].empty, vecs[i].full,
                   vecs[i].af, vecs[i].ov, vecs[i].un, vecs[i].dout);
    end

    // Streaming at count=2; 20 pops over 4 entries wraps both pointers 5 times.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 16'(16'h0100 + i));
      model_q.push_back(bus.din);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b1, 16'(16'h0102 + i));
      model_q.push_back(bus.din);
      exp_w = model_q.pop_front();
      #1 chk($sformatf("stream%0d.dout", i), 32'(bus.dout), 32'(exp_w));
      @(posedge clk);
      #1 chk($sformatf("stream%0d.count", i), 32'(bus.count), 32'd2);
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0);

    // Refill to 2 entries after a clear, then assert reset between edges.
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    @(posedge clk);
    #1 drive(1'b0, 1'b1, 1'b0, 16'h00C1);
    @(posedge clk);
    #1 drive(1'b0, 1'b1, 1'b0, 16'h00C2);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 16'h0);
    chk_state("refill", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00C1);
    #2 rst_n = 1'b0;
    #1 chk_state("async_rst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    @(posedge clk);
    #1 chk_state("in_rst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 16'h00D1);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 16'h0);
    chk_state("post_rst_push", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00D1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
